seq_chunk_adder: RTL

Parametrised multi-cycle carry adder/subtractor, successor to the fixed 14-bit carry adder. Processes CHUNK bits per clock through a ripple chunk adder, with carry held in a register between chunks. Valid/ready handshakes on input and output allow it to sit between the operand-select logic and the result register bank. Trades latency for area; supports add/sub mode and reports carry-out and signed overflow.

---
 rtl/seq_chunk_adder_pkg.sv | 14 +
 rtl/seq_chunk_adder_chunk.sv | 29 ++
 rtl/seq_chunk_adder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the multi-cycle chunked carry adder.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational ripple adder over one CHUNK-bit slice; also exposes the
// carry into its MSB so the caller can derive signed overflow.
module chunk_carry_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/sub: one CHUNK-bit slice per clock with the carry held
// in a register between slices, valid/ready on both sides.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   BUSY  | adding slice idx, one slice per clock
//   DONE  | out_valid=1, result held until out_ready
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK    = ceil_div(WIDTH, CHUNK);
  localparam int PADW      = NCHUNK * CHUNK;
  localparam int LAST_BITS = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int IDXW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [PADW-1:0]  a_q, b_q, wrk_q, wrk_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic [CHUNK-1:0] x, y, s;
  logic             ch_cout, ch_cmsb;
  logic             fin_cout, fin_cin_msb;

  // Operands are zero-padded to a whole number of slices, which masks the
  // unused upper bits of a partial last slice.
  assign x = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign y = b_q[int'(idx_q) * CHUNK +: CHUNK];

  chunk_carry_adder #(.CHUNK(CHUNK)) u_chunk (
    .x    (x),
    .y    (y),
    .cin  (carry_q),
    .s    (s),
    .cout (ch_cout),
    .c_msb(ch_cmsb)
  );

  // With a partial last slice the real carry-out lands in sum bit LAST_BITS
  // (padding bits are zero), and the carry into bit WIDTH-1 is recovered
  // from that bit's sum and operands.
  generate
    if (LAST_BITS < CHUNK) begin : g_partial
      logic c_msb_unused;
      assign c_msb_unused = ch_cmsb;
      assign fin_cout     = s[LAST_BITS];
      assign fin_cin_msb  = s[LAST_BITS-1] ^ x[LAST_BITS-1] ^ y[LAST_BITS-1];
    end else begin : g_full
      assign fin_cout    = ch_cout;
      assign fin_cin_msb = ch_cmsb;
    end
  endgenerate

  always_comb begin
    wrk_d = wrk_q;
    wrk_d[int'(idx_q) * CHUNK +: CHUNK] = s;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      wrk_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= PADW'(a);
            b_q     <= PADW'(b ^ {WIDTH{sub}});
            carry_q <= sub;
            idx_q   <= '0;
            wrk_q   <= '0;
          end
        end
        BUSY: begin
          wrk_q   <= wrk_d;
          carry_q <= ch_cout;
          if (idx_q == LAST_IDX) begin
            idx_q  <= '0;
            sum_q  <= wrk_d[WIDTH-1:0];
            cout_q <= fin_cout;
            ovf_q  <= fin_cin_msb ^ fin_cout;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
